// File: rtl/multicycle_control_unit_if.sv
// Control-unit bus: opcode and memory handshake in, datapath control lines out.
// The control unit attaches through the slave modport; the driver of the datapath side uses master.
interface multicycle_control_unit_if;
  logic [3:0] opcode;
  logic       MemReady;
  logic       RegDst;
  logic       Branch;
  logic       MemRead;
  logic       MemWrite;
  logic       RegWrite;
  logic       MemToReg;
  logic       ALUSrc;
  logic [1:0] ALUOp;
  logic       PCWrite;
  logic       IRWrite;
  logic       Halted;
  logic       BusError;
  logic       IllegalOp;
  logic [3:0] state;

  modport master (
    output opcode, MemReady,
    input  RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
           ALUOp, PCWrite, IRWrite, Halted, BusError, IllegalOp, state
  );

  modport slave (
    input  opcode, MemReady,
    output RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
           ALUOp, PCWrite, IRWrite, Halted, BusError, IllegalOp, state
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore multi-cycle control FSM for the 24-bit CPU: fetch/decode/execute/memory/writeback
// sequencing with a bounded data-memory wait that traps to a sticky bus-error state.
module multicycle_control_unit #(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input logic                         Clock,
  input logic                         Reset,
  multicycle_control_unit_if.slave    bus
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_MEM_RD = 4'd5,
    S_MEM_WB = 4'd6,
    S_MEM_WR = 4'd7,
    S_BRANCH = 4'd8,
    S_HALT   = 4'd9,
    S_ERROR  = 4'd10
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_ANDI  = 4'b0010;
  localparam logic [3:0] OP_LW    = 4'b0011;
  localparam logic [3:0] OP_SW    = 4'b0100;
  localparam logic [3:0] OP_BEQ   = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] op_q, op_d;
  logic       illegal_q, illegal_d;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_RST;
      wait_q    <= '0;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
    end
  end

  // The wait counter is zero outside the memory states, so every entry starts it fresh.
  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    op_d      = op_q;
    illegal_d = 1'b0;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        op_d = bus.opcode;
        case (bus.opcode)
          OP_RTYPE:         state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI: state_d = S_EXEC_I;
          OP_LW:            state_d = S_MEM_RD;
          OP_SW:            state_d = S_MEM_WR;
          OP_BEQ:           state_d = S_BRANCH;
          OP_HALT:          state_d = S_HALT;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I, S_BRANCH, S_MEM_WB: state_d = S_FETCH;
      S_MEM_RD: begin
        if (bus.MemReady)           state_d = S_MEM_WB;
        else if (wait_q == WAIT_LAST) state_d = S_ERROR;
        else                        wait_d  = wait_q + 8'd1;
      end
      S_MEM_WR: begin
        if (bus.MemReady)           state_d = S_FETCH;
        else if (wait_q == WAIT_LAST) state_d = S_ERROR;
        else                        wait_d  = wait_q + 8'd1;
      end
      S_HALT:   state_d = S_HALT;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_RST;
    endcase
  end

  logic       reg_dst, branch, mem_read, mem_write, reg_write, mem_to_reg, alu_src;
  logic [1:0] alu_op;
  logic       pc_write, ir_write, halted, bus_error;

  always_comb begin
    reg_dst    = 1'b0;
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    halted     = 1'b0;
    bus_error  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        pc_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_op    = 2'b10;
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_EXEC_I: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        alu_op    = (op_q == OP_ANDI) ? 2'b11 : 2'b00;
      end
      S_MEM_RD: begin
        alu_src  = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        alu_src    = 1'b1;
      end
      S_MEM_WR: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_BRANCH: begin
        branch = 1'b1;
        alu_op = 2'b01;
      end
      S_HALT:  halted    = 1'b1;
      S_ERROR: bus_error = 1'b1;
      default: ;
    endcase
  end

  assign bus.RegDst    = reg_dst;
  assign bus.Branch    = branch;
  assign bus.MemRead   = mem_read;
  assign bus.MemWrite  = mem_write;
  assign bus.RegWrite  = reg_write;
  assign bus.MemToReg  = mem_to_reg;
  assign bus.ALUSrc    = alu_src;
  assign bus.ALUOp     = alu_op;
  assign bus.PCWrite   = pc_write;
  assign bus.IRWrite   = ir_write;
  assign bus.Halted    = halted;
  assign bus.BusError  = bus_error;
  assign bus.IllegalOp = illegal_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each stimulus cycle queues the expected state/control word; a monitor
// pops and compares one entry after every rising edge.
module tb_multicycle_control_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_control_unit_if bus_if ();

  multicycle_control_unit #(.MEM_WAIT_MAX(4)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus_if)
  );

  // {state[3:0], RegDst, Branch, MemRead, MemWrite, RegWrite, MemToReg, ALUSrc,
  //  ALUOp[1:0], PCWrite, IRWrite, Halted, BusError, IllegalOp}
  localparam logic [17:0] E_RST    = {4'd0,  14'b0_0_0_0_0_0_0_00_0_0_0_0_0};
  localparam logic [17:0] E_FETCH  = {4'd1,  14'b0_0_0_0_0_0_0_00_1_1_0_0_0};
  localparam logic [17:0] E_FETCHI = {4'd1,  14'b0_0_0_0_0_0_0_00_1_1_0_0_1};
  localparam logic [17:0] E_DECODE = {4'd2,  14'b0_0_0_0_0_0_0_00_0_0_0_0_0};
  localparam logic [17:0] E_EXECR  = {4'd3,  14'b1_0_0_0_1_0_0_10_0_0_0_0_0};
  localparam logic [17:0] E_ADDI   = {4'd4,  14'b0_0_0_0_1_0_1_00_0_0_0_0_0};
  localparam logic [17:0] E_ANDI   = {4'd4,  14'b0_0_0_0_1_0_1_11_0_0_0_0_0};
  localparam logic [17:0] E_MEMRD  = {4'd5,  14'b0_0_1_0_0_0_1_00_0_0_0_0_0};
  localparam logic [17:0] E_MEMWB  = {4'd6,  14'b0_0_1_0_1_1_1_00_0_0_0_0_0};
  localparam logic [17:0] E_MEMWR  = {4'd7,  14'b0_0_0_1_0_0_1_00_0_0_0_0_0};
  localparam logic [17:0] E_BRANCH = {4'd8,  14'b0_1_0_0_0_0_0_01_0_0_0_0_0};
  localparam logic [17:0] E_HALT   = {4'd9,  14'b0_0_0_0_0_0_0_00_0_0_1_0_0};
  localparam logic [17:0] E_ERROR  = {4'd10, 14'b0_0_0_0_0_0_0_00_0_0_0_1_0};

  typedef struct {
    logic [17:0] v;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic logic [17:0] observed();
    return {bus_if.state, bus_if.RegDst, bus_if.Branch, bus_if.MemRead, bus_if.MemWrite,
            bus_if.RegWrite, bus_if.MemToReg, bus_if.ALUSrc, bus_if.ALUOp, bus_if.PCWrite,
            bus_if.IRWrite, bus_if.Halted, bus_if.BusError, bus_if.IllegalOp};
  endfunction

  always @(posedge clk) begin
    exp_t        item;
    logic [17:0] got;
    #1;
    cyc = cyc + 1;
    if (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      got  = observed();
      total = total + 1;
      if (got !== item.v) begin
        bad = bad + 1;
        $display("FAIL cyc=%0d %s: got state=%0d ctl=%b, want state=%0d ctl=%b",
                 cyc, item.name, got[17:14], got[13:0], item.v[17:14], item.v[13:0]);
      end else begin
        $display("ok   cyc=%0d %s: state=%0d ctl=%b", cyc, item.name, got[17:14], got[13:0]);
      end
    end
  end

  // Inputs set here are sampled by the next rising edge; 'e' is the state that edge produces.
  task automatic step(input logic r, input logic [3:0] op, input logic rdy,
                      input logic [17:0] e, input string name);
    exp_t item;
    @(negedge clk);
    rst             = r;
    bus_if.opcode   = op;
    bus_if.MemReady = rdy;
    item.v    = e;
    item.name = name;
    exp_q.push_back(item);
  endtask

  initial begin
    bus_if.opcode   = 4'd0;
    bus_if.MemReady = 1'b0;

    // Reset held two cycles, then an R-type (MemReady high must not matter here)
    step(1, 4'h0, 0, E_RST,    "rst0");
    step(1, 4'h0, 0, E_RST,    "rst1");
    step(0, 4'h0, 1, E_FETCH,  "r_fetch");
    step(0, 4'h0, 1, E_DECODE, "r_decode");
    step(0, 4'h0, 1, E_EXECR,  "r_exec");
    step(0, 4'h0, 0, E_FETCH,  "r_fetch2");

    // LW, MemReady arrives on the third MEM_RD cycle
    step(0, 4'h3, 0, E_DECODE, "lw_decode");
    step(0, 4'h3, 0, E_MEMRD,  "lw_rd1");
    step(0, 4'h3, 0, E_MEMRD,  "lw_rd2");
    step(0, 4'h3, 0, E_MEMRD,  "lw_rd3");
    step(0, 4'h3, 1, E_MEMWB,  "lw_wb");
    step(0, 4'h3, 0, E_FETCH,  "lw_fetch");

    // BEQ, ANDI, ADDI
    step(0, 4'h5, 0, E_DECODE, "beq_decode");
    step(0, 4'h5, 0, E_BRANCH, "beq_branch");
    step(0, 4'h2, 0, E_FETCH,  "beq_fetch");
    step(0, 4'h2, 0, E_DECODE, "andi_decode");
    step(0, 4'h2, 0, E_ANDI,   "andi_exec");
    step(0, 4'h1, 0, E_FETCH,  "andi_fetch");
    step(0, 4'h1, 0, E_DECODE, "addi_decode");
    step(0, 4'h1, 0, E_ADDI,   "addi_exec");
    step(0, 4'hA, 0, E_FETCH,  "addi_fetch");

    // Illegal opcode: one-cycle IllegalOp pulse, back to FETCH
    step(0, 4'hA, 0, E_DECODE, "ill_decode");
    step(0, 4'hA, 0, E_FETCHI, "ill_fetch_pulse");
    step(0, 4'h4, 0, E_DECODE, "ill_pulse_gone");

    // SW completing on the last allowed wait cycle (no trap)
    step(0, 4'h4, 0, E_MEMWR,  "sw_last_wr1");
    step(0, 4'h4, 0, E_MEMWR,  "sw_last_wr2");
    step(0, 4'h4, 0, E_MEMWR,  "sw_last_wr3");
    step(0, 4'h4, 0, E_MEMWR,  "sw_last_wr4");
    step(0, 4'h4, 1, E_FETCH,  "sw_last_done");

    // SW timeout: four MemWrite cycles, then sticky BusError
    step(0, 4'h4, 0, E_DECODE, "swto_decode");
    step(0, 4'h4, 0, E_MEMWR,  "swto_wr1");
    step(0, 4'h4, 0, E_MEMWR,  "swto_wr2");
    step(0, 4'h4, 0, E_MEMWR,  "swto_wr3");
    step(0, 4'h4, 0, E_MEMWR,  "swto_wr4");
    step(0, 4'h4, 0, E_ERROR,  "swto_error");
    step(0, 4'h0, 1, E_ERROR,  "swto_sticky1");
    step(0, 4'h0, 1, E_ERROR,  "swto_sticky2");
    step(1, 4'h0, 0, E_RST,    "swto_reset");
    step(0, 4'h4, 0, E_FETCH,  "swto_refetch");

    // Reset during the second MEM_WR cycle drops MemWrite next cycle
    step(0, 4'h4, 0, E_DECODE, "swrst_decode");
    step(0, 4'h4, 0, E_MEMWR,  "swrst_wr1");
    step(0, 4'h4, 0, E_MEMWR,  "swrst_wr2");
    step(1, 4'h4, 0, E_RST,    "swrst_reset");
    step(0, 4'h4, 0, E_FETCH,  "swrst_fetch");
    step(0, 4'h4, 0, E_DECODE, "swrst_decode2");
    step(0, 4'h4, 0, E_MEMWR,  "swrst_wr_again");
    step(0, 4'hF, 1, E_FETCH,  "swrst_done");

    // HALT holds for 20 cycles, then reset releases it
    step(0, 4'hF, 0, E_DECODE, "halt_decode");
    step(0, 4'hF, 0, E_HALT,   "halt_enter");
    for (int i = 0; i < 20; i++) begin
      step(0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), E_HALT, "halt_hold");
    end
    step(1, 4'h0, 0, E_RST,    "halt_reset");
    step(0, 4'h0, 0, E_FETCH,  "halt_refetch");

    // Drain the scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
